tl_error_responder: RTL and testbench



---
 rtl/tl_error_responder.sv | 150 +++++++++++++++
 tb/tb_tl_error_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_error_responder.sv
// TileLink slave that answers every request with a denied response.
// Optional err_count saturating counter: define TL_ERROR_RESPONDER_COUNT_EN.
module tl_error_responder #(
  parameter int SOURCE_W   = 4,
  parameter int SIZE_W     = 4,
  parameter int BEAT_SHIFT = 2,
  parameter int MAX_SIZE   = 6
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [SIZE_W-1:0]   a_size,
  input  logic [SOURCE_W-1:0] a_source,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [SIZE_W-1:0]   d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic                d_corrupt,
  output logic                d_last,
  input  logic                e_valid,
  output logic                e_ready,
  output logic [15:0]         err_count
);

  localparam int CNT_W = MAX_SIZE - BEAT_SHIFT + 1;

  typedef enum logic [1:0] {
    IDLE, DRAIN, RESP, WAIT_E
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic [SIZE_W-1:0]   size_q;
  logic [SOURCE_W-1:0] src_q;
  logic [CNT_W-1:0]    a_cnt_q, d_cnt_q;
  logic [CNT_W-1:0]    a_m1, d_m1;
  logic [2:0]          op_map;
  logic                a_fire, d_fire, cnt_zero;

  // Beats minus one; oversize requests are clamped before counting.
  function automatic logic [CNT_W-1:0] beats_m1(
    input logic [SIZE_W-1:0] sz
  );
    logic [SIZE_W-1:0] c;
    logic [CNT_W-1:0]  one;
    c   = (sz > SIZE_W'(MAX_SIZE)) ? SIZE_W'(MAX_SIZE) : sz;
    one = CNT_W'(1);
    if (c <= SIZE_W'(BEAT_SHIFT)) return '0;
    return (one << (c - SIZE_W'(BEAT_SHIFT))) - one;
  endfunction

  always_comb begin
    op_map = 3'd0;
    unique case (1'b1)
      (a_opcode <= 3'd1):                     op_map = 3'd0;
      (a_opcode >= 3'd2 && a_opcode <= 3'd4): op_map = 3'd1;
      (a_opcode == 3'd5):                     op_map = 3'd2;
      (a_opcode >= 3'd6):                     op_map = 3'd4;
      default:                                op_map = 3'd0;
    endcase
  end

  assign a_m1     = (a_opcode <= 3'd3) ? beats_m1(a_size) : '0;
  assign d_m1     = (op_map == 3'd1) ? beats_m1(a_size) : '0;
  assign a_fire   = a_valid & a_ready;
  assign d_fire   = d_valid & d_ready;
  assign cnt_zero = (d_cnt_q == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (a_fire) state_d = (a_m1 != '0) ? DRAIN : RESP;
      DRAIN:
        if (a_fire && a_cnt_q == CNT_W'(1)) state_d = RESP;
      RESP:
        if (d_fire && cnt_zero)
          state_d = (op_q == 3'd4) ? WAIT_E : IDLE;
      WAIT_E:
        if (e_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_ready = 1'b0;
    d_valid = 1'b0;
    unique case (state_q)
      IDLE:    a_ready = 1'b1;
      DRAIN:   a_ready = 1'b1;
      RESP:    d_valid = 1'b1;
      WAIT_E:  ;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= '0;
      size_q  <= '0;
      src_q   <= '0;
      a_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && a_fire) begin
        op_q    <= op_map;
        size_q  <= a_size;
        src_q   <= a_source;
        a_cnt_q <= a_m1;
        d_cnt_q <= d_m1;
      end else if (state_q == DRAIN && a_fire) begin
        a_cnt_q <= a_cnt_q - CNT_W'(1);
      end
      if (d_fire && !cnt_zero) d_cnt_q <= d_cnt_q - CNT_W'(1);
    end
  end

  assign d_opcode  = op_q;
  assign d_size    = size_q;
  assign d_source  = src_q;
  assign d_denied  = d_valid;
  assign d_corrupt = d_valid & (op_q == 3'd1);
  assign d_last    = d_valid & cnt_zero;
  assign e_ready   = 1'b1;

`ifdef TL_ERROR_RESPONDER_COUNT_EN
  logic [15:0] err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      err_q <= '0;
    else if (d_fire && d_last && err_q != 16'hFFFF)
      err_q <= err_q + 16'd1;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_tl_error_responder.sv
// Directed self-checking bench for tl_error_responder.
// Drives and samples on the falling edge; the DUT acts on the rising edge.
module tb_tl_error_responder;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [2:0] a_opcode = '0;
  logic [3:0] a_size = '0;
  logic [3:0] a_source = '0;
  logic       d_valid;
  logic       d_ready = 1'b0;
  logic [2:0] d_opcode;
  logic [3:0] d_size;
  logic [3:0] d_source;
  logic       d_denied;
  logic       d_corrupt;
  logic       d_last;
  logic       e_valid = 1'b0;
  logic       e_ready;
  logic [15:0] err_count;

  int vecs = 0;
  int errs = 0;

  tl_error_responder dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied),
    .d_corrupt(d_corrupt), .d_last(d_last),
    .e_valid(e_valid), .e_ready(e_ready),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  // Packs {a_ready,d_valid,d_opcode,d_size,d_source,
  //        d_denied,d_corrupt,d_last} for compact comparisons.
  function automatic logic [15:0] obs();
    return {a_ready, d_valid, d_opcode, d_size,
            d_source, d_denied, d_corrupt, d_last};
  endfunction

  function automatic logic [15:0] exp_v(
    input logic ar, input logic dv, input logic [2:0] op,
    input logic [3:0] sz, input logic [3:0] src,
    input logic dn, input logic cr, input logic ls
  );
    return {ar, dv, op, sz, src, dn, cr, ls};
  endfunction

  task automatic test_reset();
    logic [15:0] e;
    @(negedge clock);
    vecs++;
    e = exp_v(1, 0, 0, 0, 0, 0, 0, 0);
    if (obs() !== e) begin
      errs++;
      $display("FAIL reset: got %h want %h", obs(), e);
    end
    vecs++;
    if (err_count !== 16'd0 || e_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_cnt: got %h/%b want 0/1",
               err_count, e_ready);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_get();
    logic [15:0] e;
    a_valid = 1; a_opcode = 4; a_size = 4; a_source = 3;
    d_ready = 1;
    @(negedge clock);
    a_valid = 0;
    for (int i = 0; i < 4; i++) begin
      vecs++;
      e = exp_v(0, 1, 1, 4, 3, 1, 1, i == 3);
      if (obs() !== e) begin
        errs++;
        $display("FAIL get_beat%0d: got %h want %h", i, obs(), e);
      end
      @(negedge clock);
    end
    vecs++;
    if (d_valid !== 0 || a_ready !== 1) begin
      errs++;
      $display("FAIL get_done: got dv=%b ar=%b want 0/1",
               d_valid, a_ready);
    end
  endtask

  task automatic test_put_gap();
    logic [15:0] e;
    a_valid = 1; a_opcode = 0; a_size = 3; a_source = 5;
    d_ready = 1;
    @(negedge clock);
    a_valid = 0;
    vecs++;
    if (a_ready !== 1 || d_valid !== 0) begin
      errs++;
      $display("FAIL put_drain: got ar=%b dv=%b want 1/0",
               a_ready, d_valid);
    end
    @(negedge clock);
    a_valid = 1; a_opcode = 4; a_size = 6; a_source = 9;
    @(negedge clock);
    a_valid = 0;
    vecs++;
    e = exp_v(0, 1, 0, 3, 5, 1, 0, 1);
    if (obs() !== e) begin
      errs++;
      $display("FAIL put_resp: got %h want %h", obs(), e);
    end
    @(negedge clock);
    vecs++;
    if (d_valid !== 0 || a_ready !== 1) begin
      errs++;
      $display("FAIL put_done: got dv=%b ar=%b want 0/1",
               d_valid, a_ready);
    end
  endtask

  task automatic test_hint_stall();
    logic [15:0] e;
    a_valid = 1; a_opcode = 5; a_size = 2; a_source = 7;
    d_ready = 0;
    @(negedge clock);
    a_source = 2;
    for (int i = 0; i < 5; i++) begin
      vecs++;
      e = exp_v(0, 1, 2, 2, 7, 1, 0, 1);
      if (obs() !== e) begin
        errs++;
        $display("FAIL hint_stall%0d: got %h want %h",
                 i, obs(), e);
      end
      @(negedge clock);
    end
    d_ready = 1;
    @(negedge clock);
    vecs++;
    e = exp_v(1, 0, 2, 2, 7, 0, 0, 0);
    if (obs() !== e) begin
      errs++;
      $display("FAIL hint_gap: got %h want %h", obs(), e);
    end
    @(negedge clock);
    a_valid = 0;
    vecs++;
    e = exp_v(0, 1, 2, 2, 2, 1, 0, 1);
    if (obs() !== e) begin
      errs++;
      $display("FAIL hint_next: got %h want %h", obs(), e);
    end
    @(negedge clock);
  endtask

  task automatic test_grant();
    logic [15:0] e;
    a_valid = 1; a_opcode = 6; a_size = 6; a_source = 1;
    d_ready = 1;
    @(negedge clock);
    a_valid = 0;
    vecs++;
    e = exp_v(0, 1, 4, 6, 1, 1, 0, 1);
    if (obs() !== e) begin
      errs++;
      $display("FAIL grant_resp: got %h want %h", obs(), e);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vecs++;
      if (a_ready !== 0 || d_valid !== 0) begin
        errs++;
        $display("FAIL grant_wait%0d: got ar=%b dv=%b want 0/0",
                 i, a_ready, d_valid);
      end
    end
    e_valid = 1;
    @(negedge clock);
    e_valid = 0;
    vecs++;
    if (a_ready !== 1) begin
      errs++;
      $display("FAIL grant_idle: got ar=%b want 1", a_ready);
    end
  endtask

  task automatic run_hint(input logic [3:0] src);
    int n;
    a_valid = 1; a_opcode = 5; a_size = 0; a_source = src;
    d_ready = 1;
    n = 0;
    while (a_ready !== 1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    a_valid = 0;
    n = 0;
    while (d_valid !== 1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    vecs++;
    if (d_valid !== 1 || d_opcode !== 3'd2 || d_source !== src) begin
      errs++;
      $display("FAIL run_hint: got dv=%b op=%0d src=%0d want 1/2/%0d",
               d_valid, d_opcode, d_source, src);
    end
    @(negedge clock);
  endtask

  task automatic test_async_reset();
    a_valid = 1; a_opcode = 4; a_size = 6; a_source = 8;
    d_ready = 1;
    @(negedge clock);
    a_valid = 0;
    for (int i = 0; i < 5; i++) @(negedge clock);
    vecs++;
    if (d_valid !== 1 || d_last !== 0) begin
      errs++;
      $display("FAIL rst_mid: got dv=%b dl=%b want 1/0",
               d_valid, d_last);
    end
    #2 reset_n = 0;
    #1;
    vecs++;
    if (d_valid !== 0 || a_ready !== 1 || d_opcode !== 0) begin
      errs++;
      $display("FAIL rst_async: got dv=%b ar=%b op=%0d want 0/1/0",
               d_valid, a_ready, d_opcode);
    end
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    run_hint(4'd6);
    vecs++;
    if (d_valid !== 0 || a_ready !== 1) begin
      errs++;
      $display("FAIL rst_after: got dv=%b ar=%b want 0/1",
               d_valid, a_ready);
    end
  endtask

  task automatic test_count();
    @(negedge clock);
    reset_n = 0;
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    run_hint(4'd1);
    run_hint(4'd2);
    run_hint(4'd3);
`ifdef TL_ERROR_RESPONDER_COUNT_EN
    vecs++;
    if (err_count !== 16'd3) begin
      errs++;
      $display("FAIL count3: got %0d want 3", err_count);
    end
    force dut.err_q = 16'hFFFF;
    #1;
    release dut.err_q;
    run_hint(4'd4);
    vecs++;
    if (err_count !== 16'hFFFF) begin
      errs++;
      $display("FAIL count_sat: got %h want ffff", err_count);
    end
`else
    vecs++;
    if (err_count !== 16'd0) begin
      errs++;
      $display("FAIL count_off: got %0d want 0", err_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_get();
    test_put_gap();
    test_hint_stall();
    test_grant();
    test_async_reset();
    test_count();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
